// File: rtl/memory_sync_clr.sv
// memory_sync_clr: single-port synchronous RAM with per-byte write enables, a registered
// read-valid flag, selectable read-during-write behaviour and a clear sequencer that writes
// CLEAR_VALUE to every word after reset or on a soft-clear request.
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-high reset
//   memoryWrite     write request
//   memoryRead      read request
//   memoryClear     soft-clear request (sampled once)
//   memoryByteEn    byte write enables, bit i covers data bits [8i+7:8i]
//   memoryWriteData write data
//   memoryAddress   word address
//   memoryOutData   registered read data
//   memoryReadValid high for one cycle after an accepted read
//   memoryBusy      high while the clear sequencer runs
module memory_sync_clr #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH,
  parameter int unsigned READ_MODE  = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memoryWrite,
  input  logic                    memoryRead,
  input  logic                    memoryClear,
  input  logic [DATA_WIDTH/8-1:0] memoryByteEn,
  input  logic [DATA_WIDTH-1:0]   memoryWriteData,
  input  logic [ADDR_WIDTH-1:0]   memoryAddress,
  output logic [DATA_WIDTH-1:0]   memoryOutData,
  output logic                    memoryReadValid,
  output logic                    memoryBusy
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic {StClear, StIdle} state_e;

  state_e                r_state, w_state_next;
  logic [IdxW-1:0]       r_ptr, w_ptr_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_read_valid;

  logic [IdxW-1:0]       w_idx;
  logic                  w_in_range;
  logic                  w_clr_en;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Extra top bit so DEPTH == 2**ADDR_WIDTH is representable in the compare.
  assign w_in_range = ({1'b0, memoryAddress} < (ADDR_WIDTH + 1)'(DEPTH));
  assign w_idx      = memoryAddress[IdxW-1:0];
  assign w_old      = r_mem[w_idx];

  always_comb begin
    w_merged = w_old;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (memoryByteEn[i]) w_merged[8*i +: 8] = memoryWriteData[8*i +: 8];
    end
  end

  // Write-first only differs from read-first when a write actually lands on this word.
  always_comb begin
    w_rd_data = '0;
    if (w_in_range) begin
      w_rd_data = (READ_MODE == 1 && w_wr_en) ? w_merged : w_old;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StClear;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = '0;
    unique case (r_state)
      StClear: begin
        if (r_ptr == LastIdx) begin
          w_state_next = StIdle;
        end else begin
          w_ptr_next = r_ptr + 1'b1;
        end
      end
      StIdle: begin
        if (memoryClear) w_state_next = StClear;
      end
      default: w_state_next = StClear;
    endcase
  end

  // Output / enable logic; a clear request in IDLE swallows any same-cycle access.
  always_comb begin
    w_busy   = (r_state == StClear);
    w_clr_en = w_busy;
    w_wr_en  = !w_busy && !memoryClear && memoryWrite && w_in_range;
    w_rd_en  = !w_busy && !memoryClear && memoryRead;
  end

  // Array has no reset; the clear sequencer initialises it.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[r_ptr] <= CLEAR_VALUE;
    end else if (w_wr_en) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data   <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_en;
      if (w_rd_en) r_out_data <= w_rd_data;
    end
  end

  assign memoryOutData   = r_out_data;
  assign memoryReadValid = r_read_valid;
  assign memoryBusy      = w_busy;

endmodule
